muldiv_unit: RTL and testbench

Parametrised iterative multiply/divide unit extending the CPU's combinational ALU with the RV32M operations (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU). It sits beside the ALU in the execute stage. Operands and op code are accepted with a start pulse. A shift-add multiplier or restoring divider iterates one bit per cycle, then returns the result with a one-cycle done strobe. RISC-V divide-by-zero and signed-overflow cases resolve in one cycle.

---
 rtl/muldiv_unit.sv | 186 ++++++++++++++++++
 tb/tb_muldiv_unit.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide unit for the execute stage.
// A shift-add multiplier and a restoring divider share one pair of
// accumulator registers and retire one bit per cycle. Divide-by-zero and
// signed overflow resolve at acceptance without iterating.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             flush,
  input  logic [2:0]       ALUOp,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] C,
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(WIDTH);

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_REM    = 3'b110;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_q;
  logic [CW-1:0]      iterCnt_q;
  logic [2:0]         opCode_q;
  logic               negResult_q;
  logic [WIDTH-1:0]   hiAcc_q;
  logic [WIDTH-1:0]   loAcc_q;
  logic [WIDTH-1:0]   operandB_q;
  logic [WIDTH-1:0]   result_q;
  logic               busy_q;
  logic               done_q;

  logic               isDivOp;
  logic               aSigned;
  logic               bSigned;
  logic               aNeg;
  logic               bNeg;
  logic [WIDTH-1:0]   aMag;
  logic [WIDTH-1:0]   bMag;
  logic               negResult_d;
  logic               divByZero;
  logic               signedOverflow;
  logic               specialCase;
  logic [WIDTH-1:0]   specialResult;

  logic [WIDTH:0]     mulSum;
  logic [WIDTH:0]     divShift;
  logic [WIDTH:0]     divDiff;
  logic               divFits;
  logic [WIDTH-1:0]   hiAcc_d;
  logic [WIDTH-1:0]   loAcc_d;
  logic [2*WIDTH-1:0] product;
  logic [2*WIDTH-1:0] productFixed;
  logic [WIDTH-1:0]   divRaw;
  logic [WIDTH-1:0]   mulResult;
  logic [WIDTH-1:0]   divResult;
  logic [WIDTH-1:0]   result_d;
  logic               lastIter;

  // Decode the incoming request: operand magnitudes, result sign and the
  // one-cycle special cases (divide by zero, most-negative / -1).
  always_comb begin
    isDivOp        = ALUOp[2];
    aSigned        = (ALUOp == OP_MULH) || (ALUOp == OP_MULHSU) ||
                     (ALUOp == OP_DIV)  || (ALUOp == OP_REM);
    bSigned        = (ALUOp == OP_MULH) || (ALUOp == OP_DIV) || (ALUOp == OP_REM);
    aNeg           = aSigned && A[WIDTH-1];
    bNeg           = bSigned && B[WIDTH-1];
    aMag           = aNeg ? (~A + 1'b1) : A;
    bMag           = bNeg ? (~B + 1'b1) : B;
    negResult_d    = (isDivOp && ALUOp[1]) ? aNeg : (aNeg ^ bNeg);
    divByZero      = isDivOp && (B == '0);
    signedOverflow = isDivOp && !ALUOp[0] &&
                     (A == {1'b1, {(WIDTH-1){1'b0}}}) && (B == '1);
    specialCase    = divByZero || signedOverflow;
    if (divByZero) begin
      specialResult = ALUOp[1] ? A : '1;
    end else begin
      specialResult = ALUOp[1] ? '0 : A;
    end
  end

  // One iteration of the shared core: hiAcc/loAcc hold product high/low for
  // multiply and remainder/quotient for divide. On the last iteration the
  // sign fix-up and result selection are applied to the next-state values.
  always_comb begin
    mulSum   = {1'b0, hiAcc_q} + (loAcc_q[0] ? {1'b0, operandB_q} : '0);
    divShift = {hiAcc_q, loAcc_q[WIDTH-1]};
    divDiff  = divShift - {1'b0, operandB_q};
    divFits  = !divDiff[WIDTH];
    if (opCode_q[2]) begin
      hiAcc_d = divFits ? divDiff[WIDTH-1:0] : divShift[WIDTH-1:0];
      loAcc_d = {loAcc_q[WIDTH-2:0], divFits};
    end else begin
      hiAcc_d = mulSum[WIDTH:1];
      loAcc_d = {mulSum[0], loAcc_q[WIDTH-1:1]};
    end
    product      = {hiAcc_d, loAcc_d};
    productFixed = negResult_q ? (~product + 1'b1) : product;
    mulResult    = (opCode_q == OP_MUL) ? productFixed[WIDTH-1:0]
                                        : productFixed[2*WIDTH-1:WIDTH];
    divRaw       = opCode_q[1] ? hiAcc_d : loAcc_d;
    divResult    = negResult_q ? (~divRaw + 1'b1) : divRaw;
    result_d     = opCode_q[2] ? divResult : mulResult;
    lastIter     = (iterCnt_q == CW'(WIDTH - 1));
  end

  // Control FSM and datapath registers; flush overrides everything but reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      iterCnt_q   <= '0;
      opCode_q    <= '0;
      negResult_q <= 1'b0;
      hiAcc_q     <= '0;
      loAcc_q     <= '0;
      operandB_q  <= '0;
      result_q    <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else if (flush) begin
      state_q   <= IDLE;
      iterCnt_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          done_q <= 1'b0;
          busy_q <= 1'b0;
          state_q <= IDLE;
          if (start) begin
            opCode_q    <= ALUOp;
            negResult_q <= negResult_d;
            operandB_q  <= bMag;
            if (specialCase) begin
              result_q <= specialResult;
              state_q  <= DONE;
              done_q   <= 1'b1;
            end else begin
              hiAcc_q   <= '0;
              loAcc_q   <= aMag;
              iterCnt_q <= '0;
              state_q   <= CALC;
              busy_q    <= 1'b1;
            end
          end
        end
        CALC: begin
          hiAcc_q <= hiAcc_d;
          loAcc_q <= loAcc_d;
          if (lastIter) begin
            result_q <= result_d;
            state_q  <= DONE;
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
          end else begin
            iterCnt_q <= iterCnt_q + CW'(1);
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign C    = result_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed checks of muldiv_unit at WIDTH=32 and WIDTH=8,
// covering results, latency, special cases, flush, ignored start, reset and
// back-to-back issue.
module tb_muldiv_unit;

  localparam logic [2:0] MUL    = 3'b000;
  localparam logic [2:0] MULH   = 3'b001;
  localparam logic [2:0] MULHSU = 3'b010;
  localparam logic [2:0] MULHU  = 3'b011;
  localparam logic [2:0] DIV    = 3'b100;
  localparam logic [2:0] DIVU   = 3'b101;
  localparam logic [2:0] REM    = 3'b110;
  localparam logic [2:0] REMU   = 3'b111;

  logic        clock;
  logic        reset;
  logic        flush;
  logic        start32;
  logic        start8;
  logic [2:0]  aluOp;
  logic [31:0] opA;
  logic [31:0] opB;
  logic [31:0] c32;
  logic [7:0]  c8;
  logic        busy32;
  logic        busy8;
  logic        done32;
  logic        done8;

  int checkCount;
  int errorCount;

  muldiv_unit #(.WIDTH(32)) dut32 (
    .clk   (clock),
    .rst   (reset),
    .start (start32),
    .flush (flush),
    .ALUOp (aluOp),
    .A     (opA),
    .B     (opB),
    .C     (c32),
    .busy  (busy32),
    .done  (done32)
  );

  muldiv_unit #(.WIDTH(8)) dut8 (
    .clk   (clock),
    .rst   (reset),
    .start (start8),
    .flush (flush),
    .ALUOp (aluOp),
    .A     (opA[7:0]),
    .B     (opB[7:0]),
    .C     (c8),
    .busy  (busy8),
    .done  (done8)
  );

  // Free-running clock, period 10.
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Compare one observed value against its expected value and tally it.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
    end
  endtask

  // Called at the negedge after edge t0+k0; returns at the negedge where
  // done is seen, with latency counted in edges from t0.
  task automatic waitDone(input bit narrow, input int k0, output int latency);
    int k;
    k = k0;
    while (!(narrow ? done8 : done32) && (k < k0 + 200)) begin
      @(posedge clock);
      @(negedge clock);
      k++;
    end
    latency = k + 1;
  endtask

  // Issue one operation, then check busy, latency and the result.
  task automatic applyStimulus(input string tag, input bit narrow,
                               input logic [2:0] op, input logic [31:0] a,
                               input logic [31:0] b, input logic [31:0] expC,
                               input int expLatency, input bit expBusy);
    int latency;
    @(negedge clock);
    aluOp = op;
    opA   = a;
    opB   = b;
    if (narrow) start8 = 1'b1;
    else        start32 = 1'b1;
    @(posedge clock);
    @(negedge clock);
    start32 = 1'b0;
    start8  = 1'b0;
    checkOutput({tag, " busy"}, 32'(narrow ? busy8 : busy32), 32'(expBusy));
    waitDone(narrow, 0, latency);
    checkOutput({tag, " latency"}, 32'(latency), 32'(expLatency));
    checkOutput({tag, " C"}, narrow ? {24'b0, c8} : c32, expC);
  endtask

  // Global time limit so the run always ends.
  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] time limit reached");
  end

  // Directed scenarios.
  initial begin
    int latency;
    int latency2;
    bit doneSeen;
    checkCount = 0;
    errorCount = 0;
    reset   = 1'b1;
    flush   = 1'b0;
    start32 = 1'b0;
    start8  = 1'b0;
    aluOp   = MUL;
    opA     = '0;
    opB     = '0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    checkOutput("reset C", c32, 32'h0);
    checkOutput("reset busy", 32'(busy32), 32'h0);
    checkOutput("reset done", 32'(done32), 32'h0);
    reset = 1'b0;

    applyStimulus("MUL", 1'b0, MUL, 32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFEB, 33, 1'b1);
    @(posedge clock);
    @(negedge clock);
    checkOutput("MUL done drops", 32'(done32), 32'h0);
    applyStimulus("MULH", 1'b0, MULH, 32'h80000000, 32'h80000000, 32'h40000000, 33, 1'b1);
    applyStimulus("MULHU", 1'b0, MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33, 1'b1);
    applyStimulus("MULHSU", 1'b0, MULHSU, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF, 33, 1'b1);
    applyStimulus("DIV", 1'b0, DIV, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, 33, 1'b1);
    applyStimulus("REM", 1'b0, REM, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 33, 1'b1);
    applyStimulus("DIVU", 1'b0, DIVU, 32'h00000007, 32'h00000002, 32'h00000003, 33, 1'b1);
    applyStimulus("DIVU by zero", 1'b0, DIVU, 32'h00000005, 32'h0, 32'hFFFFFFFF, 1, 1'b0);
    applyStimulus("REM by zero", 1'b0, REM, 32'h00000005, 32'h0, 32'h00000005, 1, 1'b0);
    applyStimulus("DIV by zero", 1'b0, DIV, 32'hFFFFFFF9, 32'h0, 32'hFFFFFFFF, 1, 1'b0);
    applyStimulus("DIV overflow", 1'b0, DIV, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1, 1'b0);
    applyStimulus("REM overflow", 1'b0, REM, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1, 1'b0);
    applyStimulus("REMU", 1'b0, REMU, 32'h00000007, 32'h00000002, 32'h00000001, 33, 1'b1);

    // Flush a DIVU at edge t0+10; C must keep the REMU result.
    @(negedge clock);
    aluOp = DIVU; opA = 32'd100; opB = 32'd7; start32 = 1'b1;
    @(posedge clock);
    @(negedge clock);
    start32 = 1'b0;
    repeat (9) @(posedge clock);
    @(negedge clock);
    flush = 1'b1;
    @(posedge clock);
    @(negedge clock);
    flush = 1'b0;
    checkOutput("flush busy", 32'(busy32), 32'h0);
    checkOutput("flush done", 32'(done32), 32'h0);
    doneSeen = 1'b0;
    repeat (40) begin
      @(posedge clock);
      @(negedge clock);
      if (done32) doneSeen = 1'b1;
    end
    checkOutput("flush no done", 32'(doneSeen), 32'h0);
    checkOutput("flush C kept", c32, 32'h00000001);

    // A second start at t0+5 with other operands is ignored.
    @(negedge clock);
    aluOp = MUL; opA = 32'd3; opB = 32'd5; start32 = 1'b1;
    @(posedge clock);
    @(negedge clock);
    start32 = 1'b0;
    repeat (4) @(posedge clock);
    @(negedge clock);
    aluOp = DIVU; opA = 32'd100; opB = 32'd3; start32 = 1'b1;
    @(posedge clock);
    @(negedge clock);
    start32 = 1'b0;
    waitDone(1'b0, 5, latency);
    checkOutput("ignored start latency", 32'(latency), 32'd33);
    checkOutput("ignored start C", c32, 32'd15);

    // Back-to-back: start held through the DONE cycle.
    @(negedge clock);
    aluOp = MUL; opA = 32'd2; opB = 32'd3; start32 = 1'b1;
    @(posedge clock);
    @(negedge clock);
    waitDone(1'b0, 0, latency);
    checkOutput("b2b first latency", 32'(latency), 32'd33);
    checkOutput("b2b first C", c32, 32'd6);
    opA = 32'd4; opB = 32'd5;
    @(posedge clock);
    @(negedge clock);
    start32 = 1'b0;
    checkOutput("b2b second busy", 32'(busy32), 32'h1);
    waitDone(1'b0, 0, latency2);
    checkOutput("b2b total latency", 32'(latency + latency2), 32'd66);
    checkOutput("b2b second C", c32, 32'd20);
    @(posedge clock);
    @(negedge clock);
    checkOutput("b2b done drops", 32'(done32), 32'h0);

    // Asynchronous reset in the middle of CALC.
    @(negedge clock);
    aluOp = MUL; opA = 32'd9; opB = 32'd9; start32 = 1'b1;
    @(posedge clock);
    @(negedge clock);
    start32 = 1'b0;
    repeat (5) @(posedge clock);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("async reset C", c32, 32'h0);
    checkOutput("async reset busy", 32'(busy32), 32'h0);
    checkOutput("async reset done", 32'(done32), 32'h0);
    @(negedge clock);
    reset = 1'b0;

    // WIDTH=8 instance, truncated operands.
    applyStimulus("W8 MUL", 1'b1, MUL, 32'h07, 32'hFD, 32'hEB, 9, 1'b1);
    applyStimulus("W8 MULH", 1'b1, MULH, 32'h80, 32'h80, 32'h40, 9, 1'b1);
    applyStimulus("W8 MULHU", 1'b1, MULHU, 32'hFF, 32'hFF, 32'hFE, 9, 1'b1);
    applyStimulus("W8 MULHSU", 1'b1, MULHSU, 32'hFF, 32'h02, 32'hFF, 9, 1'b1);
    applyStimulus("W8 DIV", 1'b1, DIV, 32'hF9, 32'h02, 32'hFD, 9, 1'b1);
    applyStimulus("W8 DIVU by zero", 1'b1, DIVU, 32'h05, 32'h00, 32'hFF, 1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
